// File: rtl/cafeteira_uc_if.sv
// ----------------------------------------------------------------------------
// cafeteira_uc_if
//   Bundle of every signal exchanged between the coffee-maker control unit
//   (cafeteira_uc) and its surroundings: the panel and serial-order inputs,
//   the datapath status flags, the datapath control strobes and the
//   done/error/debug indications.
//
//   modport master : the control unit (reads status, drives controls)
//   modport slave  : the datapath / panel side (drives status, reads controls)
//
//   Panel / serial inputs : ligar, cancelar, pronto_serial
//   Cup sensor status     : pronto_sensor_xicara, timeout_xicara, tem_xicara
//   Brew status           : fim_bomba, fim_ebulidor, timeout_ebulidor,
//                           fim_valvula, fim_contagem, fim_espera_fim
//   Datapath clears       : zera_sensor_xicara, zera_bomba, zera_valvula,
//                           zera_ebulidor, zera_serial
//   Datapath enables      : verifica_xicara, liga_bomba, liga_ebulidor,
//                           liga_valvula, conta_interferencia, conta_fim
//   Indications           : pronto, erro, db_estado[3:0]
// ----------------------------------------------------------------------------
interface cafeteira_uc_if;
    // Panel and serial-order inputs
    logic       ligar;
    logic       cancelar;
    logic       pronto_serial;

    // Datapath status flags
    logic       pronto_sensor_xicara;
    logic       timeout_xicara;
    logic       tem_xicara;
    logic       fim_bomba;
    logic       fim_ebulidor;
    logic       timeout_ebulidor;
    logic       fim_valvula;
    logic       fim_contagem;
    logic       fim_espera_fim;

    // Datapath clears
    logic       zera_sensor_xicara;
    logic       zera_bomba;
    logic       zera_valvula;
    logic       zera_ebulidor;
    logic       zera_serial;

    // Datapath enables
    logic       verifica_xicara;
    logic       liga_bomba;
    logic       liga_ebulidor;
    logic       liga_valvula;
    logic       conta_interferencia;
    logic       conta_fim;

    // Indications
    logic       pronto;
    logic       erro;
    logic [3:0] db_estado;

    modport master (
        input  ligar, cancelar, pronto_serial,
        input  pronto_sensor_xicara, timeout_xicara, tem_xicara,
        input  fim_bomba, fim_ebulidor, timeout_ebulidor,
        input  fim_valvula, fim_contagem, fim_espera_fim,
        output zera_sensor_xicara, zera_bomba, zera_valvula,
        output zera_ebulidor, zera_serial,
        output verifica_xicara, liga_bomba, liga_ebulidor,
        output liga_valvula, conta_interferencia, conta_fim,
        output pronto, erro, db_estado
    );

    modport slave (
        output ligar, cancelar, pronto_serial,
        output pronto_sensor_xicara, timeout_xicara, tem_xicara,
        output fim_bomba, fim_ebulidor, timeout_ebulidor,
        output fim_valvula, fim_contagem, fim_espera_fim,
        input  zera_sensor_xicara, zera_bomba, zera_valvula,
        input  zera_ebulidor, zera_serial,
        input  verifica_xicara, liga_bomba, liga_ebulidor,
        input  liga_valvula, conta_interferencia, conta_fim,
        input  pronto, erro, db_estado
    );
endinterface

// File: rtl/cafeteira_uc.sv
// ----------------------------------------------------------------------------
// cafeteira_uc
//   Moore control unit of the coffee maker. Waits for an order from the ESP
//   serial link, checks for a cup (retrying up to MAX_TENTATIVAS times),
//   then fills, heats, settles, pours and holds before clearing the datapath
//   and waiting for the next order. Cancel and error handling included.
//
//   Parameters
//     MAX_TENTATIVAS : cup-detection attempts before ERRO_XICARA (1..7)
//
//   Ports
//     clock : system clock (50 MHz)
//     reset : asynchronous, active-low reset
//     bus   : cafeteira_uc_if.master -- status in, controls/indications out
//
//   All outputs are decoded from the state register only, so they never
//   carry combinational input terms.
// ----------------------------------------------------------------------------
module cafeteira_uc #(
    parameter int MAX_TENTATIVAS = 3
) (
    input  logic           clock,
    input  logic           reset,
    cafeteira_uc_if.master bus
);

    localparam logic [2:0] MAX_T = 3'(MAX_TENTATIVAS);

    typedef enum logic [3:0] {
        INICIAL       = 4'h0,
        ZERA          = 4'h1,
        ESPERA_PEDIDO = 4'h2,
        MEDE          = 4'h3,
        ESPERA_MEDIDA = 4'h4,
        ENCHE         = 4'h5,
        AQUECE        = 4'h6,
        INTERFERENCIA = 4'h7,
        DESPEJA       = 4'h8,
        ESPERA_FIM    = 4'h9,
        FIM           = 4'hA,
        CANCELA       = 4'hC,
        ERRO_XICARA   = 4'hE,
        ERRO_EBULIDOR = 4'hF
    } estado_t;

    estado_t    r_estado;
    estado_t    w_prox;
    logic [2:0] r_tent;
    logic [2:0] w_tent_next;
    logic [2:0] w_tent_inc;
    logic       w_falha_xicara;
    logic       w_cancelavel;

    logic w_zera;
    logic w_verifica_xicara;
    logic w_liga_bomba;
    logic w_liga_ebulidor;
    logic w_liga_valvula;
    logic w_conta_interferencia;
    logic w_conta_fim;
    logic w_pronto;
    logic w_erro;

    // Attempt counter saturates at 7 so it can never wrap back into range.
    assign w_tent_inc = (r_tent == 3'd7) ? 3'd7 : (r_tent + 3'd1);

    // A timeout counts as a failed attempt even if a reading arrives in the
    // same cycle; only a clean reading with a cup present is a success.
    assign w_falha_xicara = bus.timeout_xicara |
                            (bus.pronto_sensor_xicara & ~bus.tem_xicara);

    // Only states with an operation in progress (or an error latched) can be
    // aborted; idle, clearing and completion states ignore cancelar.
    always_comb begin
        w_cancelavel = 1'b0;
        case (r_estado)
            MEDE, ESPERA_MEDIDA, ENCHE, AQUECE, INTERFERENCIA,
            DESPEJA, ESPERA_FIM, ERRO_XICARA, ERRO_EBULIDOR:
                w_cancelavel = 1'b1;
            default:
                w_cancelavel = 1'b0;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_estado <= INICIAL;
            r_tent   <= 3'd0;
        end else begin
            r_estado <= w_prox;
            r_tent   <= w_tent_next;
        end
    end

    // Next-state and attempt-counter logic
    always_comb begin
        w_prox      = r_estado;
        w_tent_next = r_tent;

        if (bus.cancelar && w_cancelavel) begin
            w_prox = CANCELA;
        end else begin
            case (r_estado)
                INICIAL: begin
                    if (bus.ligar)
                        w_prox = ZERA;
                end
                ZERA: begin
                    w_tent_next = 3'd0;
                    w_prox      = ESPERA_PEDIDO;
                end
                ESPERA_PEDIDO: begin
                    // Powering off wins over a late order.
                    if (!bus.ligar)
                        w_prox = INICIAL;
                    else if (bus.pronto_serial)
                        w_prox = MEDE;
                end
                MEDE: begin
                    w_prox = ESPERA_MEDIDA;
                end
                ESPERA_MEDIDA: begin
                    if (w_falha_xicara) begin
                        w_tent_next = w_tent_inc;
                        w_prox      = (w_tent_inc < MAX_T) ? MEDE : ERRO_XICARA;
                    end else if (bus.pronto_sensor_xicara && bus.tem_xicara) begin
                        w_prox = ENCHE;
                    end
                end
                ENCHE: begin
                    if (bus.fim_bomba)
                        w_prox = AQUECE;
                end
                AQUECE: begin
                    if (bus.timeout_ebulidor)
                        w_prox = ERRO_EBULIDOR;
                    else if (bus.fim_ebulidor)
                        w_prox = INTERFERENCIA;
                end
                INTERFERENCIA: begin
                    if (bus.fim_contagem)
                        w_prox = DESPEJA;
                end
                DESPEJA: begin
                    if (bus.fim_valvula)
                        w_prox = ESPERA_FIM;
                end
                ESPERA_FIM: begin
                    if (bus.fim_espera_fim)
                        w_prox = FIM;
                end
                FIM: begin
                    // Pass through ZERA so the next order starts from a
                    // cleared datapath and a fresh attempt count.
                    w_prox = ZERA;
                end
                CANCELA: begin
                    w_tent_next = 3'd0;
                    w_prox      = ESPERA_PEDIDO;
                end
                ERRO_XICARA, ERRO_EBULIDOR: begin
                    w_prox = r_estado;
                end
                default: begin
                    w_prox = INICIAL;
                end
            endcase
        end
    end

    // Moore output decode
    always_comb begin
        w_zera                = 1'b0;
        w_verifica_xicara     = 1'b0;
        w_liga_bomba          = 1'b0;
        w_liga_ebulidor       = 1'b0;
        w_liga_valvula        = 1'b0;
        w_conta_interferencia = 1'b0;
        w_conta_fim           = 1'b0;
        w_pronto              = 1'b0;
        w_erro                = 1'b0;
        case (r_estado)
            ZERA, CANCELA:                w_zera                = 1'b1;
            MEDE:                         w_verifica_xicara     = 1'b1;
            ENCHE:                        w_liga_bomba          = 1'b1;
            AQUECE:                       w_liga_ebulidor       = 1'b1;
            INTERFERENCIA:                w_conta_interferencia = 1'b1;
            DESPEJA:                      w_liga_valvula        = 1'b1;
            ESPERA_FIM:                   w_conta_fim           = 1'b1;
            FIM:                          w_pronto              = 1'b1;
            ERRO_XICARA, ERRO_EBULIDOR:   w_erro                = 1'b1;
            default: ;
        endcase
    end

    assign bus.zera_sensor_xicara  = w_zera;
    assign bus.zera_bomba          = w_zera;
    assign bus.zera_valvula        = w_zera;
    assign bus.zera_ebulidor       = w_zera;
    assign bus.zera_serial         = w_zera;
    assign bus.verifica_xicara     = w_verifica_xicara;
    assign bus.liga_bomba          = w_liga_bomba;
    assign bus.liga_ebulidor       = w_liga_ebulidor;
    assign bus.liga_valvula        = w_liga_valvula;
    assign bus.conta_interferencia = w_conta_interferencia;
    assign bus.conta_fim           = w_conta_fim;
    assign bus.pronto              = w_pronto;
    assign bus.erro                = w_erro;
    assign bus.db_estado           = r_estado;

    // Pump, heater and valve must never be energised together.
    a_atuadores_exclusivos: assert property (
        @(posedge clock) disable iff (!reset)
        $onehot0({w_liga_bomba, w_liga_ebulidor, w_liga_valvula})
    );

endmodule

// File: tb/tb_cafeteira_uc.sv
module tb_cafeteira_uc;

    localparam int MAX_T = 3;

    // Status bit positions inside st
    localparam logic [9:0] B_SER = 10'h001;  // pronto_serial
    localparam logic [9:0] B_PSX = 10'h002;  // pronto_sensor_xicara
    localparam logic [9:0] B_TOX = 10'h004;  // timeout_xicara
    localparam logic [9:0] B_TEM = 10'h008;  // tem_xicara
    localparam logic [9:0] B_FBO = 10'h010;  // fim_bomba
    localparam logic [9:0] B_FEB = 10'h020;  // fim_ebulidor
    localparam logic [9:0] B_TEB = 10'h040;  // timeout_ebulidor
    localparam logic [9:0] B_FVA = 10'h080;  // fim_valvula
    localparam logic [9:0] B_FCO = 10'h100;  // fim_contagem
    localparam logic [9:0] B_FEF = 10'h200;  // fim_espera_fim
    localparam logic [9:0] M_MED = B_PSX | B_TOX | B_TEM;

    // Expected output word layout:
    // [12:8] zera x5, [7] verifica, [6] bomba, [5] ebulidor, [4] valvula,
    // [3] conta_interferencia, [2] conta_fim, [1] pronto, [0] erro
    logic        clock    = 1'b0;
    logic        reset    = 1'b0;
    logic        ligar    = 1'b0;
    logic        cancelar = 1'b0;
    logic [9:0]  st       = 10'h000;
    logic [12:0] outs;
    int          vectors     = 0;
    int          miscompares = 0;

    cafeteira_uc_if bus();

    assign bus.ligar                = ligar;
    assign bus.cancelar             = cancelar;
    assign bus.pronto_serial        = st[0];
    assign bus.pronto_sensor_xicara = st[1];
    assign bus.timeout_xicara       = st[2];
    assign bus.tem_xicara           = st[3];
    assign bus.fim_bomba            = st[4];
    assign bus.fim_ebulidor         = st[5];
    assign bus.timeout_ebulidor     = st[6];
    assign bus.fim_valvula          = st[7];
    assign bus.fim_contagem         = st[8];
    assign bus.fim_espera_fim       = st[9];

    assign outs = {bus.zera_sensor_xicara, bus.zera_bomba, bus.zera_valvula,
                   bus.zera_ebulidor, bus.zera_serial, bus.verifica_xicara,
                   bus.liga_bomba, bus.liga_ebulidor, bus.liga_valvula,
                   bus.conta_interferencia, bus.conta_fim, bus.pronto, bus.erro};

    cafeteira_uc #(.MAX_TENTATIVAS(MAX_T)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.master)
    );

    always #5 clock = ~clock;

    // Output word required in each state, straight from the action table.
    function automatic logic [12:0] exp_outs(input logic [3:0] code);
        case (code)
            4'h1, 4'hC: return 13'h1F00;
            4'h3:       return 13'h0080;
            4'h5:       return 13'h0040;
            4'h6:       return 13'h0020;
            4'h7:       return 13'h0008;
            4'h8:       return 13'h0010;
            4'h9:       return 13'h0004;
            4'hA:       return 13'h0002;
            4'hE, 4'hF: return 13'h0001;
            default:    return 13'h0000;
        endcase
    endfunction

    function automatic logic [9:0] trig_fail();
        logic [9:0] t;
        case ($urandom_range(0, 2))
            0: t = B_TOX;
            1: begin
                t = B_TOX | B_PSX;
                if ($urandom_range(0, 1) == 1) t = t | B_TEM;
            end
            default: t = B_PSX;
        endcase
        return t;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Sit in state `code` for a random number of cycles with irrelevant
    // status noise, then apply the trigger for one cycle. Cancels the
    // operation on the trigger cycle when code == cancel_at.
    task automatic run_phase(input logic [3:0] code, input logic [9:0] mask,
                             input logic [9:0] trig, input bit canc_noise,
                             input int maxd, input logic [3:0] cancel_at,
                             output bit cancelled);
        int d;
        d = $urandom_range(0, maxd);
        for (int i = 0; i <= d; i++) begin
            vectors++;
            if (bus.db_estado !== code) begin
                miscompares++;
                $display("FAIL phase_state: db_estado=%h required %h", bus.db_estado, code);
            end
            vectors++;
            if (outs !== exp_outs(code)) begin
                miscompares++;
                $display("FAIL phase_outs state %h: outputs=%h required %h", code, outs, exp_outs(code));
            end
            if (i < d) begin
                st       = 10'($urandom) & ~mask;
                cancelar = canc_noise ? 1'($urandom) : 1'b0;
                tick();
            end
        end
        st        = (10'($urandom) & ~mask) | trig;
        cancelled = (code == cancel_at);
        cancelar  = cancelled | (canc_noise & 1'($urandom));
        tick();
        st       = 10'h000;
        cancelar = 1'b0;
    endtask

    task automatic finish_cancel();
        bit c;
        run_phase(4'hC, 10'h000, 10'h000, 1'b1, 0, 4'h0, c);
        vectors++;
        if (bus.db_estado !== 4'h2 || outs !== 13'h0) begin
            miscompares++;
            $display("FAIL after_cancel: state=%h outs=%h required state 2 outs 0", bus.db_estado, outs);
        end
    endtask

    // One order from ESPERA_PEDIDO: `fails` failed cup readings, heater
    // outcome (0 ok, 1 timeout, 2 timeout+fim together), optional cancel.
    task automatic do_order(input int fails, input int heat_mode, input logic [3:0] cancel_at);
        bit c;
        logic [9:0] t;
        run_phase(4'h2, B_SER, B_SER, 1'b1, 3, cancel_at, c);
        for (int k = 0; k <= fails; k++) begin
            run_phase(4'h3, 10'h000, 10'h000, 1'b0, 0, cancel_at, c);
            if (c) begin finish_cancel(); return; end
            t = (k < fails) ? trig_fail() : (B_PSX | B_TEM);
            run_phase(4'h4, M_MED, t, 1'b0, 3, cancel_at, c);
            if (c) begin finish_cancel(); return; end
            if (k < fails && k + 1 == MAX_T) begin
                run_phase(4'hE, 10'h000, 10'h000, 1'b0, 3, 4'hE, c);
                finish_cancel();
                return;
            end
        end
        run_phase(4'h5, B_FBO, B_FBO, 1'b0, 3, cancel_at, c);
        if (c) begin finish_cancel(); return; end
        t = (heat_mode == 0) ? B_FEB : (heat_mode == 1) ? B_TEB : (B_TEB | B_FEB);
        run_phase(4'h6, B_FEB | B_TEB, t, 1'b0, 3, cancel_at, c);
        if (c) begin finish_cancel(); return; end
        if (heat_mode != 0) begin
            run_phase(4'hF, 10'h000, 10'h000, 1'b0, 3, 4'hF, c);
            finish_cancel();
            return;
        end
        run_phase(4'h7, B_FCO, B_FCO, 1'b0, 3, cancel_at, c);
        if (c) begin finish_cancel(); return; end
        run_phase(4'h8, B_FVA, B_FVA, 1'b0, 3, cancel_at, c);
        if (c) begin finish_cancel(); return; end
        run_phase(4'h9, B_FEF, B_FEF, 1'b0, 3, cancel_at, c);
        if (c) begin finish_cancel(); return; end
        run_phase(4'hA, 10'h000, 10'h000, 1'b1, 0, 4'h0, c);
        run_phase(4'h1, 10'h000, 10'h000, 1'b1, 0, 4'h0, c);
        vectors++;
        if (bus.db_estado !== 4'h2 || outs !== 13'h0) begin
            miscompares++;
            $display("FAIL after_brew: state=%h outs=%h required state 2 outs 0", bus.db_estado, outs);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clock);
        #1;
        vectors++;
        if (bus.db_estado !== 4'h0 || outs !== 13'h0) begin
            miscompares++;
            $display("FAIL reset_hold: state=%h outs=%h required 0/0", bus.db_estado, outs);
        end
        #3 reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            st = 10'($urandom);
            cancelar = 1'b1;
            tick();
            vectors++;
            if (bus.db_estado !== 4'h0 || outs !== 13'h0) begin
                miscompares++;
                $display("FAIL idle_no_ligar: state=%h outs=%h required 0/0", bus.db_estado, outs);
            end
        end
        st = 10'h000;
        cancelar = 1'b0;
        for (int r = 0; r < 2; r++) begin
            ligar = 1'b1;
            tick();
            vectors++;
            if (bus.db_estado !== 4'h1 || outs !== 13'h1F00) begin
                miscompares++;
                $display("FAIL power_on_zera: state=%h outs=%h required 1/1f00", bus.db_estado, outs);
            end
            tick();
            vectors++;
            if (bus.db_estado !== 4'h2 || outs !== 13'h0) begin
                miscompares++;
                $display("FAIL wait_order: state=%h outs=%h required 2/0", bus.db_estado, outs);
            end
            if (r == 0) begin
                ligar = 1'b0;
                tick();
                vectors++;
                if (bus.db_estado !== 4'h0) begin
                    miscompares++;
                    $display("FAIL power_off: state=%h required 0", bus.db_estado);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        st = B_SER;          tick();
        st = 10'h000;        tick();
        st = B_PSX | B_TEM;  tick();
        st = B_FBO;          tick();
        st = 10'h000;
        vectors++;
        if (bus.db_estado !== 4'h6 || bus.liga_ebulidor !== 1'b1) begin
            miscompares++;
            $display("FAIL reach_aquece: state=%h liga_ebulidor=%b required 6/1", bus.db_estado, bus.liga_ebulidor);
        end
        #3 reset = 1'b0;
        #1;
        vectors++;
        if (bus.db_estado !== 4'h0 || outs !== 13'h0) begin
            miscompares++;
            $display("FAIL async_reset: state=%h outs=%h required 0/0", bus.db_estado, outs);
        end
        #2 reset = 1'b1;
        tick();
        vectors++;
        if (bus.db_estado !== 4'h1 || outs !== 13'h1F00) begin
            miscompares++;
            $display("FAIL zera_after_reset: state=%h outs=%h required 1/1f00", bus.db_estado, outs);
        end
        tick();
        vectors++;
        if (bus.db_estado !== 4'h2) begin
            miscompares++;
            $display("FAIL order_after_reset: state=%h required 2", bus.db_estado);
        end
    endtask

    task automatic test_normal_brew();
        do_order(0, 0, 4'h0);
    endtask

    task automatic test_no_cup();
        do_order(MAX_T, 0, 4'h0);
    endtask

    task automatic test_second_attempt();
        do_order(1, 0, 4'h0);
        do_order(MAX_T - 1, 0, 4'h0);
    endtask

    task automatic test_heater_fault();
        do_order(0, 2, 4'h0);
        do_order(0, 1, 4'h0);
    endtask

    task automatic test_cancel_despeja();
        do_order(0, 0, 4'h8);
    endtask

    task automatic test_random_orders();
        int f;
        int h;
        logic [3:0] ca;
        for (int n = 0; n < 40; n++) begin
            f  = $urandom_range(0, MAX_T);
            h  = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 2) : 0;
            ca = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(3, 9)) : 4'h0;
            do_order(f, h, ca);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid();
        test_normal_brew();
        test_no_cup();
        test_second_attempt();
        test_heater_fault();
        test_cancel_despeja();
        test_random_orders();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
